// File: rtl/lsu_pkg.sv
// Shared types, func3 encodings and store/alignment helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_MISAL = 2'b01,
        ERR_ILL   = 2'b10,
        ERR_TMO   = 2'b11
    } lsu_err_e;

    function automatic logic func3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic is_store, input logic [2:0] f3,
                                            input logic [1:0] off);
        if (!is_store) begin
            return 4'b1111;
        end
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the narrow data puts it on every lane, so byte enables alone pick the target.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response bundle and word-wide data-memory bundle for lsu_ctrl.
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    modport master (output req_valid, is_store, func3, address, wdata,
                    input  req_ready, resp_valid, resp_data, resp_err);
    modport slave  (input  req_valid, is_store, func3, address, wdata,
                    output req_ready, resp_valid, resp_data, resp_err);
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_ctrl_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational; unknown func3 yields zero.
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (byte_off)
            2'd0:    lane_b = raw[7:0];
            2'd1:    lane_b = raw[15:8];
            2'd2:    lane_b = raw[23:16];
            default: lane_b = raw[31:24];
        endcase
        lane_h = byte_off[1] ? raw[31:16] : raw[15:0];

        case (func3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_W:    result = raw;
            F3_BU:   result = {24'd0, lane_b};
            F3_HU:   result = {16'd0, lane_h};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access at a time, alignment/func3 checks, bounded wait on gnt/rvalid.
// Response 1 cycle after accept on error, 2 for a granted store, 3+ for loads; no response backpressure.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    lsu_core_if.slave   core,
    lsu_mem_if.master   mem
);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              st_q, st_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    lsu_err_e          resp_err_q, resp_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [31:0]       load_res;
    logic [CNT_W-1:0]  cnt_inc;
    logic              tmo_hit;

    load_align u_align (
        .func3    (f3_q),
        .byte_off (off_q),
        .raw      (mem.mem_rdata),
        .result   (load_res)
    );

    assign cnt_inc = cnt_q + 1'b1;
    // Fires on the last permitted REQ/WAIT_R cycle; the awaited event in that cycle still wins.
    assign tmo_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        st_d         = st_q;
        f3_d         = f3_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (core.req_valid) begin
                    st_d  = core.is_store;
                    f3_d  = core.func3;
                    off_d = core.address[1:0];
                    cnt_d = '0;
                    if (!func3_legal(core.is_store, core.func3)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_ILL;
                        resp_data_d  = 32'd0;
                    end else if (addr_misaligned(core.func3, core.address[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_MISAL;
                        resp_data_d  = 32'd0;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = core.is_store;
                        mem_be_d    = store_be(core.is_store, core.func3, core.address[1:0]);
                        mem_addr_d  = {core.address[31:2], 2'b00};
                        mem_wdata_d = store_wdata(core.func3, core.wdata);
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (mem.mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (st_q) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_OK;
                        resp_data_d  = 32'd0;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end else if (tmo_hit) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TMO;
                    resp_data_d  = 32'd0;
                end
            end
            ST_WAIT_R: begin
                cnt_d = cnt_inc;
                if (mem.mem_rvalid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    resp_data_d  = load_res;
                end else if (tmo_hit) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TMO;
                    resp_data_d  = 32'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            st_q         <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= ERR_OK;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            st_q         <= st_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign core.req_ready  = (state_q == ST_IDLE);
    assign core.resp_valid = resp_valid_q;
    assign core.resp_data  = resp_data_q;
    assign core.resp_err   = resp_err_q;
    assign mem.mem_req     = mem_req_q;
    assign mem.mem_we      = mem_we_q;
    assign mem.mem_be      = mem_be_q;
    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wdata   = mem_wdata_q;

endmodule
